// File: rtl/keyfile_pkg.sv
// Shared register map, bit positions and FSM encoding for the keyfile reader.
package keyfile_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned KEY_W  = 64;

    // Byte offsets from the peripheral base address
    localparam logic [3:0] OFS_CTRL = 4'h0;
    localparam logic [3:0] OFS_STAT = 4'h2;
    localparam logic [3:0] OFS_KEY0 = 4'h4;
    localparam logic [3:0] OFS_KEY1 = 4'h6;
    localparam logic [3:0] OFS_KEY2 = 4'h8;
    localparam logic [3:0] OFS_KEY3 = 4'hA;

    // CTRL bit positions
    localparam int unsigned CTRL_SNAP  = 0;
    localparam int unsigned CTRL_ABORT = 1;
    localparam int unsigned CTRL_IE    = 2;
    localparam int unsigned CTRL_CLR   = 3;

    // STAT bit positions
    localparam int unsigned STAT_VALID   = 0;
    localparam int unsigned STAT_BUSY    = 1;
    localparam int unsigned STAT_CHANGED = 2;
    localparam int unsigned STAT_ERR     = 3;

    // FSM encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETTLE   = 2'd1;
    localparam logic [1:0] ST_CAPTURED = 2'd2;

endpackage

// File: rtl/keyfile_reader_if.sv
// openMSP430 peripheral bus as seen by the keyfile reader.
interface keyfile_reader_if;
    import keyfile_pkg::*;

    logic [ADDR_W-1:0] per_addr;
    logic [DATA_W-1:0] per_din;
    logic              per_en;
    logic [1:0]        per_we;
    logic [DATA_W-1:0] per_dout;

    modport master (output per_addr, per_din, per_en, per_we, input  per_dout);
    modport slave  (input  per_addr, per_din, per_en, per_we, output per_dout);

endinterface

// File: rtl/keyfile_stability_monitor.sv
// Tracks how many consecutive cycles the live key has held the same value.
module keyfile_stability_monitor
    import keyfile_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic             stable_done_c_o,
    output logic             key_eq_c_o
);

    localparam int unsigned CNT_W = 8;

    logic [KEY_W-1:0] key_prev_q;
    logic [CNT_W-1:0] stable_cnt_q;
    logic [CNT_W-1:0] stable_cnt_d;

    assign key_eq_c_o      = (key_i == key_prev_q);
    assign stable_done_c_o = enable_i && key_eq_c_o &&
                             ((stable_cnt_q + CNT_W'(1)) == CNT_W'(STABLE_CYC));

    // Run length of equal samples; a restart request overrides counting
    always_comb begin
        stable_cnt_d = stable_cnt_q;
        if (clear_i) begin
            stable_cnt_d = '0;
        end else if (enable_i) begin
            stable_cnt_d = key_eq_c_o ? (stable_cnt_q + CNT_W'(1)) : '0;
        end
    end

    // Previous-sample register runs every cycle regardless of FSM state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_prev_q   <= '0;
            stable_cnt_q <= '0;
        end else begin
            key_prev_q   <= key_i;
            stable_cnt_q <= stable_cnt_d;
        end
    end

endmodule

// File: rtl/keyfile_reader.sv
// Captures a tear-free shadow of the radio keyfile and flags later changes.
module keyfile_reader
    import keyfile_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR   = 15'h00C0,
    parameter int unsigned DEC_WD      = 4,
    parameter int unsigned STABLE_CYC  = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             mclk,
    input  logic             puc_rst,
    keyfile_reader_if.slave  bus,
    input  logic             smclk_en,
    input  logic [KEY_W-1:0] key_data_in,
    output logic             irq_key
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;

    logic              sel_c, rd_c, wr_c, ctrl_wr_c;
    logic              snap_c, abort_c, clr_c;
    logic [DEC_WD-1:0] ofs_c;
    logic              mon_clear_c, mon_en_c, mon_done_c, mon_key_eq_c;
    logic              changed_set_c, err_set_c;
    logic [DATA_W-1:0] per_dout_c;
    logic              unused_bits;

    logic [1:0]        state_q, state_d;
    logic [KEY_W-1:0]  shadow_q, shadow_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              valid_q, valid_d;
    logic              changed_q, changed_d;
    logic              err_q, err_d;
    logic              ie_q, ie_d;
    logic              irq_q;

    // Address decode and CTRL write triggers
    assign sel_c     = bus.per_en && (bus.per_addr[ADDR_W-1:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign ofs_c     = {bus.per_addr[DEC_WD-2:0], 1'b0};
    assign rd_c      = sel_c && (bus.per_we == 2'b00);
    assign wr_c      = sel_c && (bus.per_we != 2'b00);
    assign ctrl_wr_c = wr_c && (ofs_c == DEC_WD'(OFS_CTRL));
    assign snap_c    = ctrl_wr_c && bus.per_din[CTRL_SNAP];
    assign abort_c   = ctrl_wr_c && bus.per_din[CTRL_ABORT];
    assign clr_c     = ctrl_wr_c && bus.per_din[CTRL_CLR];
    assign mon_en_c  = (state_q == ST_SETTLE);

    assign unused_bits = &{1'b0, smclk_en, mon_key_eq_c, bus.per_din[DATA_W-1:4]};

    keyfile_stability_monitor #(
        .STABLE_CYC (STABLE_CYC)
    ) u_mon (
        .clk_i           (mclk),
        .rst_i           (puc_rst),
        .key_i           (key_data_in),
        .clear_i         (mon_clear_c),
        .enable_i        (mon_en_c),
        .stable_done_c_o (mon_done_c),
        .key_eq_c_o      (mon_key_eq_c)
    );

    // Next-state logic: abort beats snap, snap beats capture, capture beats timeout
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        to_cnt_d      = to_cnt_q;
        valid_d       = valid_q;
        mon_clear_c   = 1'b0;
        err_set_c     = 1'b0;
        changed_set_c = (state_q == ST_CAPTURED) && (key_data_in != shadow_q);

        if (abort_c) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else if (snap_c) begin
            state_d     = ST_SETTLE;
            valid_d     = 1'b0;
            to_cnt_d    = '0;
            mon_clear_c = 1'b1;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (mon_done_c) begin
                        shadow_d = key_data_in;
                        valid_d  = 1'b1;
                        state_d  = ST_CAPTURED;
                    end else if ((to_cnt_q + TO_W'(1)) == TO_W'(TIMEOUT_CYC)) begin
                        err_set_c = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_IDLE, ST_CAPTURED: ;
                default: state_d = ST_IDLE;
            endcase
        end

        // Sticky flags: a set condition outranks a same-cycle clear
        changed_d = (changed_q && !clr_c) || changed_set_c;
        err_d     = (err_q && !clr_c) || err_set_c;
        ie_d      = ctrl_wr_c ? bus.per_din[CTRL_IE] : ie_q;
    end

    // State and register file
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            to_cnt_q  <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
            ie_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            to_cnt_q  <= to_cnt_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            err_q     <= err_d;
            ie_q      <= ie_d;
            irq_q     <= ie_d & changed_d;
        end
    end

    assign irq_key = irq_q;

    // Read mux straight from flops; zero whenever not a selected read
    always_comb begin
        per_dout_c = '0;
        if (rd_c) begin
            case (ofs_c)
                DEC_WD'(OFS_CTRL): per_dout_c[CTRL_IE] = ie_q;
                DEC_WD'(OFS_STAT): begin
                    per_dout_c[STAT_VALID]   = valid_q;
                    per_dout_c[STAT_BUSY]    = (state_q == ST_SETTLE);
                    per_dout_c[STAT_CHANGED] = changed_q;
                    per_dout_c[STAT_ERR]     = err_q;
                end
                DEC_WD'(OFS_KEY0): per_dout_c = shadow_q[63:48];
                DEC_WD'(OFS_KEY1): per_dout_c = shadow_q[47:32];
                DEC_WD'(OFS_KEY2): per_dout_c = shadow_q[31:16];
                DEC_WD'(OFS_KEY3): per_dout_c = shadow_q[15:0];
                default: ;
            endcase
        end
    end

    assign bus.per_dout = per_dout_c;

endmodule

// File: tb/tb_keyfile_reader.sv
// Randomised and directed bench for keyfile_reader with a queue-based scoreboard.
module tb_keyfile_reader;

    localparam logic [14:0] BASE = 15'h00C0;
    localparam int          STAB = 8;
    localparam int          TMO  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        smclk_en = 1'b0;
    logic [63:0] key = 64'h0;
    logic        irq;

    keyfile_reader_if bus ();

    keyfile_reader #(
        .BASE_ADDR   (BASE),
        .DEC_WD      (4),
        .STABLE_CYC  (STAB),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .mclk        (clk),
        .puc_rst     (rst),
        .bus         (bus.slave),
        .smclk_en    (smclk_en),
        .key_data_in (key),
        .irq_key     (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [15:0] dout;
        logic        irq;
    } exp_t;

    exp_t sbq[$];

    // Reference model: capture happens STAB edges after the later of the SNAP
    // edge and the last edge that saw a new key; timeout TMO edges after SNAP.
    int          cyc = 0;
    int          snap_edge = 0;
    int          last_chg = 0;
    bit          m_settle = 0, m_capt = 0, m_valid = 0;
    bit          m_changed = 0, m_err = 0, m_ie = 0;
    logic [63:0] m_shadow = 64'h0;
    logic [63:0] m_prev = 64'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_settle = 0; m_capt = 0; m_valid = 0;
            m_changed = 0; m_err = 0; m_ie = 0;
            m_shadow = 64'h0; m_prev = 64'h0;
        end else begin : step
            bit wr_ctrl, snap, abort, clr, chg_set, err_set;
            int base;
            wr_ctrl = bus.per_en && (bus.per_we != 2'b00) && (int'(bus.per_addr) * 2 == int'(BASE));
            snap    = wr_ctrl && bus.per_din[0];
            abort   = wr_ctrl && bus.per_din[1];
            clr     = wr_ctrl && bus.per_din[3];
            if (key != m_prev) last_chg = cyc;
            chg_set = m_capt && (key != m_shadow);
            err_set = 0;
            if (abort) begin
                m_settle = 0; m_capt = 0; m_valid = 0;
            end else if (snap) begin
                m_settle = 1; m_capt = 0; m_valid = 0; snap_edge = cyc;
            end else if (m_settle) begin
                base = (snap_edge > last_chg) ? snap_edge : last_chg;
                if (cyc == base + STAB) begin
                    m_shadow = key; m_valid = 1; m_settle = 0; m_capt = 1;
                end else if (cyc == snap_edge + TMO) begin
                    err_set = 1; m_settle = 0;
                end
            end
            m_changed = (m_changed && !clr) || chg_set;
            m_err     = (m_err && !clr) || err_set;
            if (wr_ctrl) m_ie = bus.per_din[2];
            m_prev = key;
            cyc++;
        end
    end

    function automatic logic [15:0] exp_read(input logic [13:0] a);
        int ba;
        ba = int'(a) * 2;
        if (ba < int'(BASE) || ba >= int'(BASE) + 16) return 16'h0;
        case (ba - int'(BASE))
            0:       return {13'b0, m_ie, 2'b0};
            2:       return {12'b0, m_err, m_changed, m_settle, m_valid};
            4:       return m_shadow[63:48];
            6:       return m_shadow[47:32];
            8:       return m_shadow[31:16];
            10:      return m_shadow[15:0];
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic [13:0] ra(input int ofs);
        return 14'((int'(BASE) + ofs) / 2);
    endfunction

    // Monitor: every bus read cycle pops one expectation
    always @(negedge clk) begin
        if (bus.per_en && bus.per_we == 2'b00) begin
            exp_t e;
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_read: addr=%h dout=%h with empty scoreboard", bus.per_addr, bus.per_dout);
            end else begin
                e = sbq.pop_front();
                total++;
                if (bus.per_dout !== e.dout) begin
                    bad++;
                    $display("FAIL %s: per_dout=%h expected=%h at t=%0t", e.name, bus.per_dout, e.dout, $time);
                end
                total++;
                if (irq !== e.irq) begin
                    bad++;
                    $display("FAIL %s_irq: irq_key=%b expected=%b at t=%0t", e.name, irq, e.irq, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr_a(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        bus.per_addr = a; bus.per_din = d; bus.per_we = we; bus.per_en = 1'b1;
        tick();
        bus.per_en = 1'b0; bus.per_we = 2'b00;
    endtask

    task automatic wr(input int ofs, input logic [15:0] d);
        wr_a(ra(ofs), d, 2'b11);
    endtask

    // Read checked against the model
    task automatic rd(input logic [13:0] a, input string nm);
        exp_t e;
        e.name = nm; e.dout = exp_read(a); e.irq = m_ie & m_changed;
        sbq.push_back(e);
        bus.per_addr = a; bus.per_we = 2'b00; bus.per_en = 1'b1;
        tick();
        bus.per_en = 1'b0;
    endtask

    // Read checked against a fixed value
    task automatic rd_k(input int ofs, input string nm, input logic [15:0] v, input logic iq);
        exp_t e;
        e.name = nm; e.dout = v; e.irq = iq;
        sbq.push_back(e);
        bus.per_addr = ra(ofs); bus.per_we = 2'b00; bus.per_en = 1'b1;
        tick();
        bus.per_en = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.per_addr = '0; bus.per_din = '0; bus.per_en = 1'b0; bus.per_we = 2'b00;
        idle(2);
        rd_k(2, "rst_stat", 16'h0, 1'b0);
        rd_k(0, "rst_ctrl", 16'h0, 1'b0);
        rst = 1'b0;
        rd_k(4, "post_rst_key0", 16'h0, 1'b0);

        // Constant key: capture exactly STAB edges after SNAP
        key = 64'h0123_4567_89AB_CDEF;
        idle(2);
        wr(0, 16'h0001);
        idle(7);
        rd_k(2, "const_busy_e7", 16'h0002, 1'b0);
        rd_k(2, "const_valid_e8", 16'h0001, 1'b0);
        rd_k(4, "const_key0", 16'h0123, 1'b0);
        rd_k(6, "const_key1", 16'h4567, 1'b0);
        rd_k(8, "const_key2", 16'h89AB, 1'b0);
        rd_k(10, "const_key3", 16'hCDEF, 1'b0);

        // Word changes visible at +3 and +6: capture at +14 with final value
        wr(0, 16'h0001);
        idle(2);
        key[15:0] = 16'h1111;
        idle(3);
        key[15:0] = 16'h2222;
        idle(7);
        rd_k(2, "settle_e12", 16'h0002, 1'b0);
        rd_k(2, "settle_e13", 16'h0002, 1'b0);
        rd_k(2, "settle_e14", 16'h0001, 1'b0);
        rd_k(10, "settle_key3", 16'h2222, 1'b0);
        rd_k(4, "settle_key0", 16'h0123, 1'b0);

        // Key never settles: ERR at +TMO, shadow untouched
        wr(0, 16'h0001);
        for (int k = 0; k < 15; k++) begin
            idle(2);
            key[31:16] = key[31:16] ^ 16'h5A5A;
            idle(2);
        end
        idle(3);
        rd_k(2, "tmo_e63", 16'h0002, 1'b0);
        rd_k(2, "tmo_e64", 16'h0008, 1'b0);
        rd_k(8, "tmo_key2", 16'h89AB, 1'b0);
        wr(0, 16'h0008);
        rd_k(2, "tmo_clr", 16'h0000, 1'b0);

        // Change detection with interrupt
        key = 64'h0123_4567_89AB_2222;
        wr(0, 16'h0005);
        idle(8);
        rd_k(2, "chg_capt", 16'h0001, 1'b0);
        rd_k(0, "chg_ctrl_ie", 16'h0004, 1'b0);
        key[15:0] = 16'hBEEF;
        rd_k(2, "chg_before", 16'h0001, 1'b0);
        rd_k(2, "chg_after", 16'h0005, 1'b1);
        rd_k(10, "chg_shadow_kept", 16'h2222, 1'b1);
        wr(0, 16'h000C);
        rd_k(2, "chg_set_wins", 16'h0005, 1'b1);
        key[15:0] = 16'h2222;
        wr(0, 16'h000C);
        rd_k(2, "chg_cleared", 16'h0001, 1'b0);
        key[15:0] = 16'hBEEF;
        wr(0, 16'h0005);
        idle(8);
        rd_k(10, "recapt_key3", 16'hBEEF, 1'b1);
        wr(0, 16'h000C);
        rd_k(2, "recapt_clr", 16'h0001, 1'b0);

        // SNAP+ABORT together, ABORT mid-settle, reset mid-settle
        wr(0, 16'h0003);
        rd_k(2, "snap_abort", 16'h0000, 1'b0);
        idle(10);
        rd_k(2, "snap_abort_late", 16'h0000, 1'b0);
        wr(0, 16'h0001);
        idle(3);
        rd_k(2, "abort_busy", 16'h0002, 1'b0);
        wr(0, 16'h0002);
        rd_k(2, "abort_idle", 16'h0000, 1'b0);
        rd_k(10, "abort_shadow", 16'hBEEF, 1'b0);
        idle(10);
        rd_k(2, "abort_late", 16'h0000, 1'b0);
        wr(0, 16'h0005);
        idle(3);
        rst = 1'b1;
        rd_k(2, "rst_mid_stat", 16'h0000, 1'b0);
        rd_k(10, "rst_mid_key3", 16'h0000, 1'b0);
        rst = 1'b0;
        rd_k(0, "rst_mid_ctrl", 16'h0000, 1'b0);
        idle(10);
        rd_k(2, "rst_mid_late", 16'h0000, 1'b0);

        // Unselected accesses and writes to read-only registers
        key = 64'hA5A5_5A5A_1234_8765;
        wr(0, 16'h0001);
        idle(8);
        rd_k(2, "ro_capt", 16'h0001, 1'b0);
        rd_k(16, "unsel_rd", 16'h0000, 1'b0);
        rd_k(12, "hole_rd", 16'h0000, 1'b0);
        wr(4, 16'hFFFF);
        wr(10, 16'h0000);
        wr(2, 16'h00FF);
        rd_k(4, "ro_key0", 16'hA5A5, 1'b0);
        rd_k(10, "ro_key3", 16'h8765, 1'b0);
        rd_k(2, "ro_stat", 16'h0001, 1'b0);
        wr_a(ra(16), 16'h0002, 2'b11);
        rd_k(2, "unsel_wr", 16'h0001, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                key[16 * $urandom_range(0, 3) +: 16] = 16'($urandom);
                tick();
            end else if (r < 14) begin
                logic [15:0] d;
                d = 16'h0;
                d[0] = 1'($urandom_range(0, 1));
                d[1] = ($urandom_range(0, 7) == 0);
                d[2] = 1'($urandom_range(0, 1));
                d[3] = ($urandom_range(0, 3) == 0);
                wr_a(ra(0), d, 2'($urandom_range(1, 3)));
            end else if (r < 50) begin
                rd(ra(2 * int'($urandom_range(0, 7))), "rnd_rd");
            end else if (r < 53) begin
                rd(14'($urandom), "rnd_any_rd");
            end else if (r < 55) begin
                wr_a(ra(2 * int'($urandom_range(1, 7))), 16'($urandom), 2'($urandom_range(1, 3)));
            end else begin
                tick();
            end
        end

        idle(2);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
